// File: rtl/i2s_frame_ctrl.sv
// I2S format lock/mute sequencer: measures BCK periods per LRCK half, locks after
// repeated matching halves, drives delay-line taps and mutes on fault or LRCK loss.
module i2s_frame_ctrl #(
  parameter int unsigned DATA_BITS   = 24,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned MIN_HALF    = 25,
  parameter int unsigned MAX_HALF    = 64
) (
  input  logic       BCK,
  input  logic       RSTN,
  input  logic       LRCK,
  input  logic       ERR_CLR,
  output logic [5:0] TAP_R,
  output logic [6:0] TAP_L,
  output logic [6:0] HALF_LEN,
  output logic       LOCKED,
  output logic       MUTE,
  output logic       ERR,
  output logic       LED1
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  localparam int unsigned     MW        = $clog2(2 * LOCK_FRAMES + 1);
  localparam logic [MW-1:0]   MATCH_TGT = MW'(2 * LOCK_FRAMES);
  localparam logic [6:0]      MIN_L     = 7'(MIN_HALF);
  localparam logic [6:0]      MAX_L     = 7'(MAX_HALF);
  localparam logic [6:0]      CNT_MAX   = 7'd127;

  state_t        state_q, state_d;
  logic          lr_q;
  logic [6:0]    cnt_q, cnt_d;
  logic [6:0]    ref_q, ref_d;
  logic [MW-1:0] match_q, match_d;
  logic [5:0]    tap_r_q, tap_r_d;
  logic [6:0]    tap_l_q, tap_l_d;
  logic [6:0]    half_q, half_d;
  logic          locked_q, locked_d;
  logic          mute_q, mute_d;
  logic          err_q, err_d;
  logic          led_q, led_d;
  logic          lr_edge, legal, err_set;

  always_ff @(posedge BCK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      lr_q     <= 1'b0;
      cnt_q    <= '0;
      ref_q    <= '0;
      match_q  <= '0;
      tap_r_q  <= '0;
      tap_l_q  <= '0;
      half_q   <= '0;
      locked_q <= 1'b0;
      mute_q   <= 1'b1;
      err_q    <= 1'b0;
      led_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      lr_q     <= LRCK;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      tap_r_q  <= tap_r_d;
      tap_l_q  <= tap_l_d;
      half_q   <= half_d;
      locked_q <= locked_d;
      mute_q   <= mute_d;
      err_q    <= err_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    lr_edge  = LRCK ^ lr_q;
    legal    = (cnt_q >= MIN_L) && (cnt_q <= MAX_L);
    cnt_d    = lr_edge ? 7'd1 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 7'd1);
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    tap_r_d  = tap_r_q;
    tap_l_d  = tap_l_q;
    half_d   = half_q;
    locked_d = locked_q;
    mute_d   = mute_q;
    led_d    = led_q;
    err_set  = 1'b0;

    if (!lr_edge && cnt_q == CNT_MAX) begin
      state_d  = IDLE;
      mute_d   = 1'b1;
      locked_d = 1'b0;
      led_d    = 1'b1;
      err_set  = (state_q == LOCK);
    end else if (lr_edge) begin
      // cnt_q is the length of the half that just ended on this edge
      unique case (state_q)
        IDLE: begin
          // ref=0 never matches, so the first ACQ edge just loads ref with match=1
          state_d = ACQ;
          ref_d   = '0;
          match_d = '0;
        end
        ACQ: begin
          if (legal && cnt_q == ref_q) begin
            match_d = match_q + MW'(1);
            if (match_q + MW'(1) == MATCH_TGT) begin
              state_d  = LOCK;
              half_d   = ref_q;
              tap_r_d  = 6'(ref_q - 7'(DATA_BITS + 1));
              tap_l_d  = 7'({ref_q, 1'b0} - 8'(DATA_BITS + 1));
              locked_d = 1'b1;
              led_d    = 1'b0;
            end
          end else begin
            ref_d   = cnt_q;
            match_d = legal ? MW'(1) : '0;
          end
        end
        LOCK: begin
          if (cnt_q != half_q) begin
            state_d  = ACQ;
            ref_d    = cnt_q;
            match_d  = legal ? MW'(1) : '0;
            mute_d   = 1'b1;
            locked_d = 1'b0;
            led_d    = 1'b1;
            err_set  = 1'b1;
          end else if (!LRCK) begin
            mute_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    err_d = err_set ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
  end

  assign TAP_R    = tap_r_q;
  assign TAP_L    = tap_l_q;
  assign HALF_LEN = half_q;
  assign LOCKED   = locked_q;
  assign MUTE     = mute_q;
  assign ERR      = err_q;
  assign LED1     = led_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl: lock at several half lengths, format fault,
// LRCK loss, illegal format and mid-frame reset.
module tb_i2s_frame_ctrl;

  logic       BCK = 1'b0;
  logic       RSTN, LRCK, ERR_CLR;
  logic [5:0] TAP_R;
  logic [6:0] TAP_L, HALF_LEN;
  logic       LOCKED, MUTE, ERR, LED1;

  int total = 0;
  int bad   = 0;

  i2s_frame_ctrl #(.DATA_BITS(24), .LOCK_FRAMES(4), .MIN_HALF(25), .MAX_HALF(64)) dut (
    .BCK(BCK), .RSTN(RSTN), .LRCK(LRCK), .ERR_CLR(ERR_CLR),
    .TAP_R(TAP_R), .TAP_L(TAP_L), .HALF_LEN(HALF_LEN),
    .LOCKED(LOCKED), .MUTE(MUTE), .ERR(ERR), .LED1(LED1)
  );

  always #5 BCK = ~BCK;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge BCK);
    #1;
  endtask

  task automatic halves(input int n, input int k);
    repeat (k) begin
      LRCK = ~LRCK;
      wait_cyc(n);
    end
  endtask

  task automatic check_all(input string tag, input int tr, input int tl, input int hl,
                           input int lk, input int mu, input int er, input int led);
    check({tag, ".tap_r"}, TAP_R, tr);
    check({tag, ".tap_l"}, TAP_L, tl);
    check({tag, ".half"},  HALF_LEN, hl);
    check({tag, ".locked"}, LOCKED, lk);
    check({tag, ".mute"},  MUTE, mu);
    check({tag, ".err"},   ERR, er);
    check({tag, ".led"},   LED1, led);
  endtask

  initial begin
    RSTN = 1'b0; LRCK = 1'b0; ERR_CLR = 1'b0;
    wait_cyc(3);
    check_all("rst", 0, 0, 0, 0, 1, 0, 1);
    RSTN = 1'b1;

    // T5: 20-BCK halves are illegal, never lock
    halves(20, 40);
    check_all("t5", 0, 0, 0, 0, 1, 0, 1);

    // T1: 32-BCK halves, lock on the 9th edge (8th matching)
    halves(32, 8);
    check("t1.prelock", LOCKED, 0);
    halves(32, 1);
    check_all("t1.lock", 7, 39, 32, 1, 1, 0, 0);
    LRCK = ~LRCK;
    wait_cyc(1);
    @(negedge BCK);
    check("t1.unmute", MUTE, 0);
    wait_cyc(31);

    // T3: switch to 48; fault edge with ERR_CLR asserted
    halves(48, 1);
    check("t3.still_locked", LOCKED, 1);
    LRCK = ~LRCK;
    ERR_CLR = 1'b1;
    wait_cyc(1);
    ERR_CLR = 1'b0;
    @(negedge BCK);
    check_all("t3.fault", 7, 39, 32, 0, 1, 1, 1);
    wait_cyc(47);
    halves(48, 6);
    check("t3.prelock", LOCKED, 0);
    halves(48, 1);
    check_all("t3.relock", 23, 71, 48, 1, 1, 1, 0);

    // T4: unmute, then LRCK stops
    LRCK = ~LRCK;
    wait_cyc(1);
    @(negedge BCK);
    check("t4.unmute", MUTE, 0);
    wait_cyc(200);
    check_all("t4.loss", 23, 71, 48, 0, 1, 1, 1);
    ERR_CLR = 1'b1;
    wait_cyc(1);
    ERR_CLR = 1'b0;
    check("t4.errclr", ERR, 0);

    // T2: 64-BCK halves from IDLE
    halves(64, 8);
    check("t2.prelock", LOCKED, 0);
    halves(64, 1);
    check_all("t2.lock", 39, 103, 64, 1, 1, 0, 0);

    // T6: async reset mid-frame
    wait_cyc(20);
    #2 RSTN = 1'b0;
    #1;
    check_all("t6.rst", 0, 0, 0, 0, 1, 0, 1);
    LRCK = 1'b0;
    wait_cyc(3);
    RSTN = 1'b1;
    halves(64, 8);
    check("t6.prelock", LOCKED, 0);
    halves(64, 1);
    check_all("t6.relock", 39, 103, 64, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
